// File: rtl/hazard_detection_unit_pkg.sv
// hazard_detection_unit_pkg: shared constants and state encoding for the hazard unit
package hazard_detection_unit_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] X0 = '0;
  typedef enum logic {RUN, MDU_BUSY} state_t;
endpackage

// File: rtl/hazard_detection_unit_if.sv
// hazard_detection_unit_if: pipeline-side signal bundle of the hazard unit
interface hazard_detection_unit_if #(parameter int STALL_CNT_W = 16);
  import hazard_detection_unit_pkg::*;
  logic [REG_W-1:0] IFID_Rs1, IFID_Rs2, IDEX_Rd;
  logic IFID_UseRs1, IFID_UseRs2, IDEX_MemRead, IDEX_MduStart, EX_BranchTaken, StallCntClr;
  logic PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Bubble, MduBusy;
  logic [STALL_CNT_W-1:0] StallCount;
  modport master (
    output IFID_Rs1, IFID_Rs2, IFID_UseRs1, IFID_UseRs2, IDEX_Rd, IDEX_MemRead,
           IDEX_MduStart, EX_BranchTaken, StallCntClr,
    input  PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Bubble,
           MduBusy, StallCount
  );
  modport slave (
    input  IFID_Rs1, IFID_Rs2, IFID_UseRs1, IFID_UseRs2, IDEX_Rd, IDEX_MemRead,
           IDEX_MduStart, EX_BranchTaken, StallCntClr,
    output PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Bubble,
           MduBusy, StallCount
  );
endinterface

// File: rtl/hazard_detection_unit_mdu_timer.sv
// hazard_mdu_timer: holds a MUL/DIV in EX for MDU_LAT-1 cycles
module hazard_mdu_timer
  import hazard_detection_unit_pkg::*;
#(parameter int MDU_LAT = 4) (
  input  logic clk,
  input  logic rst_n,
  input  logic mdu_start,
  output logic mdu_hold
);
  state_t state, state_nxt;
  logic [5:0] cnt, cnt_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  // start cycle itself is the first stall, so the counter covers the remaining MDU_LAT-2
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    mdu_hold = 1'b0;
    if (state == RUN) begin
      if (mdu_start && MDU_LAT > 1) begin
        mdu_hold = 1'b1;
        state_nxt = MDU_BUSY;
        cnt_nxt = 6'(MDU_LAT - 2);
      end
    end else if (cnt != '0) begin
      mdu_hold = 1'b1;
      cnt_nxt = cnt - 6'd1;
    end else state_nxt = RUN;
  end
endmodule

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: stall/flush control for load-use, MUL/DIV occupancy and taken branches
module hazard_detection_unit
  import hazard_detection_unit_pkg::*;
#(parameter int MDU_LAT = 4, parameter int STALL_CNT_W = 16) (
  input logic clk,
  input logic rst_n,
  hazard_detection_unit_if.slave bus
);
  logic mdu_hold, load_use, flush, stall_lu;
  logic [STALL_CNT_W-1:0] stall_cnt;
  hazard_mdu_timer #(.MDU_LAT(MDU_LAT)) u_timer (
    .clk(clk), .rst_n(rst_n), .mdu_start(bus.IDEX_MduStart), .mdu_hold(mdu_hold)
  );
  assign load_use = bus.IDEX_MemRead && bus.IDEX_Rd != X0 &&
                    ((bus.IFID_UseRs1 && bus.IDEX_Rd == bus.IFID_Rs1) ||
                     (bus.IFID_UseRs2 && bus.IDEX_Rd == bus.IFID_Rs2));
  // a taken branch squashes the dependent instruction, so it overrides the load-use stall
  assign flush = bus.EX_BranchTaken && !mdu_hold;
  assign stall_lu = load_use && !flush && !mdu_hold;
  assign bus.PCWrite = rst_n && !mdu_hold && !stall_lu;
  assign bus.IFID_Write = rst_n && !mdu_hold && !stall_lu;
  assign bus.IDEX_Write = rst_n && !mdu_hold;
  assign bus.IFID_Flush = rst_n && flush;
  assign bus.IDEX_Bubble = rst_n && (flush || stall_lu);
  assign bus.EXMEM_Bubble = rst_n && mdu_hold;
  assign bus.MduBusy = rst_n && mdu_hold;
  assign bus.StallCount = stall_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= '0;
    else if (bus.StallCntClr) stall_cnt <= '0;
    else if (!bus.PCWrite && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb_hazard_detection_unit: directed checks on a MDU_LAT=4 unit and a MDU_LAT=1, 4-bit-counter unit
module tb_hazard_detection_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  hazard_detection_unit_if #(.STALL_CNT_W(16)) bus ();
  hazard_detection_unit_if #(.STALL_CNT_W(4)) alt ();
  hazard_detection_unit #(.MDU_LAT(4), .STALL_CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  hazard_detection_unit #(.MDU_LAT(1), .STALL_CNT_W(4)) dut_alt (.clk(clk), .rst_n(rst_n), .bus(alt));
  assign alt.IFID_Rs1 = bus.IFID_Rs1;
  assign alt.IFID_Rs2 = bus.IFID_Rs2;
  assign alt.IFID_UseRs1 = bus.IFID_UseRs1;
  assign alt.IFID_UseRs2 = bus.IFID_UseRs2;
  assign alt.IDEX_Rd = bus.IDEX_Rd;
  assign alt.IDEX_MemRead = bus.IDEX_MemRead;
  assign alt.IDEX_MduStart = bus.IDEX_MduStart;
  assign alt.EX_BranchTaken = bus.EX_BranchTaken;
  assign alt.StallCntClr = bus.StallCntClr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.IFID_Rs1 = '0; bus.IFID_Rs2 = '0; bus.IFID_UseRs1 = 0; bus.IFID_UseRs2 = 0;
    bus.IDEX_Rd = '0; bus.IDEX_MemRead = 0; bus.IDEX_MduStart = 0;
    bus.EX_BranchTaken = 0; bus.StallCntClr = 0;
  endtask

  task automatic lu(input logic [4:0] rd, input logic [4:0] rs1, input logic use1);
    bus.IDEX_MemRead = 1; bus.IDEX_Rd = rd; bus.IFID_Rs1 = rs1; bus.IFID_UseRs1 = use1;
  endtask

  initial begin
    idle();
    #3;
    chk("rst_pcwrite", 32'(bus.PCWrite), 0);
    chk("rst_idex_write", 32'(bus.IDEX_Write), 0);
    chk("rst_cnt", 32'(bus.StallCount), 0);
    step();
    rst_n = 1;
    #1;
    chk("run_pcwrite", 32'(bus.PCWrite), 1);
    chk("run_ifid_write", 32'(bus.IFID_Write), 1);
    chk("run_idex_write", 32'(bus.IDEX_Write), 1);
    chk("run_bubbles", {bus.IFID_Flush, bus.IDEX_Bubble, bus.EXMEM_Bubble, bus.MduBusy}, 0);
    lu(5, 5, 1);
    #1;
    chk("lu_pcwrite", 32'(bus.PCWrite), 0);
    chk("lu_ifid_write", 32'(bus.IFID_Write), 0);
    chk("lu_bubble", 32'(bus.IDEX_Bubble), 1);
    chk("lu_idex_write", 32'(bus.IDEX_Write), 1);
    step(); idle(); #1;
    chk("lu_cnt", 32'(bus.StallCount), 1);
    chk("lu_released", 32'(bus.PCWrite), 1);
    lu(0, 0, 1); #1;
    chk("lu_x0", 32'(bus.PCWrite), 1);
    lu(5, 5, 0); #1;
    chk("lu_nouse", 32'(bus.PCWrite), 1);
    bus.IFID_Rs2 = 5; bus.IFID_UseRs2 = 1; #1;
    chk("lu_rs2", 32'(bus.IDEX_Bubble), 1);
    step(); idle(); #1;
    chk("lu_rs2_cnt", 32'(bus.StallCount), 2);
    lu(5, 5, 1); bus.EX_BranchTaken = 1; #1;
    chk("br_flush", 32'(bus.IFID_Flush), 1);
    chk("br_bubble", 32'(bus.IDEX_Bubble), 1);
    chk("br_pcwrite", 32'(bus.PCWrite), 1);
    step(); idle(); #1;
    chk("br_cnt", 32'(bus.StallCount), 2);
    bus.IDEX_MduStart = 1; #1;
    chk("alt_mdu_pcwrite", 32'(alt.PCWrite), 1);
    chk("alt_mdu_busy", 32'(alt.MduBusy), 0);
    for (int i = 0; i < 3; i++) begin
      bus.EX_BranchTaken = (i == 1); #1;
      chk($sformatf("mdu1_busy%0d", i), {bus.MduBusy, bus.EXMEM_Bubble, bus.PCWrite, bus.IDEX_Write}, 4'b1100);
      chk($sformatf("mdu1_noflush%0d", i), 32'(bus.IFID_Flush), 0);
      step();
    end
    bus.EX_BranchTaken = 0; #1;
    chk("mdu1_release", {bus.MduBusy, bus.PCWrite, bus.IDEX_Write}, 3'b011);
    step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mdu2_busy%0d", i), {bus.MduBusy, bus.EXMEM_Bubble, bus.PCWrite}, 3'b110);
      step();
    end
    chk("mdu2_release", {bus.MduBusy, bus.PCWrite}, 2'b01);
    idle(); step();
    chk("mdu_cnt", 32'(bus.StallCount), 8);
    chk("alt_mdu_cnt", 32'(alt.StallCount), 2);
    bus.IDEX_MduStart = 1; step(); #1;
    chk("rstmid_cnt_pre", 32'(bus.StallCount), 9);
    rst_n = 0; #1;
    chk("rstmid_forced", {bus.PCWrite, bus.IFID_Write, bus.IDEX_Write, bus.MduBusy, bus.EXMEM_Bubble}, 0);
    chk("rstmid_cnt", 32'(bus.StallCount), 0);
    idle(); step();
    rst_n = 1;
    bus.IDEX_MduStart = 1; #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mdu3_busy%0d", i), {bus.MduBusy, bus.PCWrite}, 2'b10);
      step();
    end
    chk("mdu3_release", {bus.MduBusy, bus.PCWrite}, 2'b01);
    idle(); step();
    chk("mdu3_cnt", 32'(bus.StallCount), 3);
    lu(7, 7, 1);
    repeat (20) step();
    chk("sat_main", 32'(bus.StallCount), 23);
    chk("sat_alt", 32'(alt.StallCount), 15);
    chk("sat_stalling", 32'(alt.PCWrite), 0);
    bus.StallCntClr = 1; step();
    chk("clr_main", 32'(bus.StallCount), 0);
    chk("clr_alt", 32'(alt.StallCount), 0);
    idle(); step();
    chk("clr_hold", 32'(alt.StallCount), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
